// File: rtl/mips_bus_lsu.sv
// mips_bus_lsu: single-outstanding load/store unit between the MIPS execute
// stage and an Avalon-MM master port. Handles lane selection, sign/zero
// extension, LWL/LWR merging, misalignment rejection and bus timeout.
module mips_bus_lsu #(
  parameter int unsigned BIG_ENDIAN = 0,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  typedef enum logic [3:0] {
    OP_LW  = 4'd0, OP_LH  = 4'd1, OP_LHU = 4'd2, OP_LB = 4'd3, OP_LBU = 4'd4,
    OP_LWL = 4'd5, OP_LWR = 4'd6, OP_SW  = 4'd7, OP_SH = 4'd8, OP_SB  = 4'd9
  } op_t;

  localparam logic BE = (BIG_ENDIAN != 0);

  state_t      state;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic        half_q;
  logic [31:0] rt_q;
  logic [31:0] wait_cnt;

  logic [1:0]  lane_in;
  logic        half_in;
  logic        bad_in;
  logic        store_in;
  logic [3:0]  be_in;
  logic [31:0] wd_in;
  logic [31:0] load_res;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        timed_out;

  assign lane_in   = req_addr[1:0] ^ {2{BE}};
  assign half_in   = req_addr[1] ^ BE;
  assign timed_out = (TIMEOUT != 0) && ((wait_cnt + 32'd1) >= TIMEOUT);

  // Decode the incoming request: legality, byte enables and store data.
  always_comb begin
    bad_in   = 1'b0;
    store_in = 1'b0;
    be_in    = '0;
    wd_in    = req_wdata;
    case (req_op)
      OP_LW:  begin be_in = 4'b1111; bad_in = (req_addr[1:0] != 2'b00); end
      OP_SW:  begin be_in = 4'b1111; bad_in = (req_addr[1:0] != 2'b00); store_in = 1'b1; end
      OP_LH, OP_LHU: begin
        be_in  = half_in ? 4'b1100 : 4'b0011;
        bad_in = req_addr[0];
      end
      OP_SH: begin
        be_in    = half_in ? 4'b1100 : 4'b0011;
        bad_in   = req_addr[0];
        store_in = 1'b1;
        wd_in    = {2{req_wdata[15:0]}};
      end
      OP_LB, OP_LBU: be_in = 4'b0001 << lane_in;
      OP_SB: begin
        be_in    = 4'b0001 << lane_in;
        store_in = 1'b1;
        wd_in    = {4{req_wdata[7:0]}};
      end
      OP_LWL: be_in = 4'b1111 >> (2'd3 - lane_in);
      OP_LWR: be_in = 4'b1111 << lane_in;
      default: bad_in = 1'b1;
    endcase
  end

  assign byte_sel = readdata[8*lane_q +: 8];
  assign half_sel = half_q ? readdata[31:16] : readdata[15:0];

  // Shape the returned bus word into the load result for the latched op.
  always_comb begin
    load_res = '0;
    case (op_q)
      OP_LW:  load_res = readdata;
      OP_LB:  load_res = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: load_res = {24'd0, byte_sel};
      OP_LH:  load_res = {{16{half_sel[15]}}, half_sel};
      OP_LHU: load_res = {16'd0, half_sel};
      // LWL/LWR spelled out per lane instead of variable 32-bit shifts.
      OP_LWL: begin
        case (lane_q)
          2'd0:    load_res = {readdata[7:0],  rt_q[23:0]};
          2'd1:    load_res = {readdata[15:0], rt_q[15:0]};
          2'd2:    load_res = {readdata[23:0], rt_q[7:0]};
          default: load_res = readdata;
        endcase
      end
      OP_LWR: begin
        case (lane_q)
          2'd0:    load_res = readdata;
          2'd1:    load_res = {rt_q[31:24], readdata[31:8]};
          2'd2:    load_res = {rt_q[31:16], readdata[31:16]};
          default: load_res = {rt_q[31:8],  readdata[31:24]};
        endcase
      end
      default: load_res = '0;
    endcase
  end

  // Control FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      read       <= 1'b0;
      write      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      op_q       <= '0;
      lane_q     <= '0;
      half_q     <= 1'b0;
      rt_q       <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            lane_q     <= lane_in;
            half_q     <= half_in;
            rt_q       <= req_rt_old;
            address    <= {req_addr[31:2], 2'b00};
            byteenable <= be_in;
            writedata  <= wd_in;
            wait_cnt   <= '0;
            req_ready  <= 1'b0;
            if (bad_in) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else begin
              state <= S_BUS;
              read  <= !store_in;
              write <= store_in;
            end
          end
        end
        S_BUS: begin
          if (!waitrequest) begin
            read       <= 1'b0;
            write      <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= load_res;
            state      <= S_RESP;
          end else if (timed_out) begin
            read       <= 1'b0;
            write      <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= '0;
            state      <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_data  <= '0;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          read      <= 1'b0;
          write     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_lsu.sv
// Testbench for mips_bus_lsu: a little-endian instance with TIMEOUT=4 and a
// big-endian instance with no timeout, checked against a byte-level model.
module tb_mips_bus_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_rt_old, readdata;
  logic        waitrequest;

  logic        rdy [2];
  logic        rv  [2];
  logic        rerr[2];
  logic        rds [2];
  logic        wrs [2];
  logic [31:0] rdat[2];
  logic [31:0] adr [2];
  logic [31:0] wdo [2];
  logic [3:0]  beo [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_bus_lsu #(.BIG_ENDIAN(0), .TIMEOUT(4)) u_le (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(rdy[0]),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rt_old(req_rt_old), .resp_valid(rv[0]), .resp_data(rdat[0]),
    .resp_err(rerr[0]), .address(adr[0]), .read(rds[0]), .write(wrs[0]),
    .waitrequest(waitrequest), .writedata(wdo[0]), .byteenable(beo[0]),
    .readdata(readdata)
  );

  mips_bus_lsu #(.BIG_ENDIAN(1), .TIMEOUT(0)) u_be (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(rdy[1]),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rt_old(req_rt_old), .resp_valid(rv[1]), .resp_data(rdat[1]),
    .resp_err(rerr[1]), .address(adr[1]), .read(rds[1]), .write(wrs[1]),
    .waitrequest(waitrequest), .writedata(wdo[1]), .byteenable(beo[1]),
    .readdata(readdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written from the MIPS memory rules with plain arithmetic.
  task automatic model(input int w, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rt, input logic [31:0] rd,
                       output bit err, output bit st, output logic [3:0] be,
                       output logic [31:0] wdx, output logic [31:0] res);
    int unsigned l, h, b, hw;
    longint unsigned ones, r64, rt64;
    l    = (a % 4) ^ ((w == 1) ? 3 : 0);
    h    = ((a / 2) % 2) ^ ((w == 1) ? 1 : 0);
    ones = 64'hFFFF_FFFF;
    r64  = rd;
    rt64 = rt;
    b    = (rd >> (8 * l)) & 32'hFF;
    hw   = (rd >> (16 * h)) & 32'hFFFF;
    err  = (op > 9) || ((op == 1 || op == 2 || op == 8) && (a % 2 != 0))
                    || ((op == 0 || op == 7) && (a % 4 != 0));
    st   = (op >= 7) && (op <= 9);
    be   = 4'h0;
    wdx  = wd;
    res  = 32'h0;
    case (op)
      4'd0: begin be = 4'hF; res = rd; end
      4'd1: begin be = h ? 4'hC : 4'h3; res = (hw >= 32768) ? (32'hFFFF_0000 | hw) : hw; end
      4'd2: begin be = h ? 4'hC : 4'h3; res = hw; end
      4'd3: begin be = 4'(1 << l); res = (b >= 128) ? (32'hFFFF_FF00 | b) : b; end
      4'd4: begin be = 4'(1 << l); res = b; end
      4'd5: begin
        be  = 4'((1 << (l + 1)) - 1);
        res = 32'(((r64 << (8 * (3 - l))) | (rt64 & (ones >> (8 * (l + 1))))) & ones);
      end
      4'd6: begin
        be  = 4'((15 << l) & 15);
        res = 32'(((r64 >> (8 * l)) | (rt64 & ~(ones >> (8 * l)))) & ones);
      end
      4'd7: be = 4'hF;
      4'd8: begin be = h ? 4'hC : 4'h3; wdx = {2{wd[15:0]}}; end
      4'd9: begin be = 4'(1 << l); wdx = {4{wd[7:0]}}; end
      default: be = 4'h0;
    endcase
    if (err || st) res = 32'h0;
  endtask

  task automatic access(input int w, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rt, input logic [31:0] rd,
                        input int waits, input string tag);
    bit err, st, abort;
    logic [3:0]  be;
    logic [31:0] wdx, res;
    int cyc, tmo, exp_cycles;
    model(w, op, a, wd, rt, rd, err, st, be, wdx, res);
    tmo = (w == 0) ? 4 : 0;
    cyc = 0;
    while (!rdy[w] && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk({tag, "/ready"}, 32'(rdy[w]), 32'd1);
    req_op = op; req_addr = a; req_wdata = wd; req_rt_old = rt;
    readdata = rd; waitrequest = 1'b0; req_valid[w] = 1'b1;
    @(posedge clk); #1;
    req_valid[w] = 1'b0;
    if (err) begin
      chk({tag, "/rej_valid"}, 32'(rv[w]), 32'd1);
      chk({tag, "/rej_err"}, 32'(rerr[w]), 32'd1);
      chk({tag, "/rej_data"}, rdat[w], 32'd0);
      chk({tag, "/rej_strobe"}, {30'd0, rds[w], wrs[w]}, 32'd0);
    end else begin
      abort      = (tmo > 0) && (waits >= tmo);
      exp_cycles = abort ? tmo : waits + 1;
      cyc = 0;
      while (!rv[w] && cyc < 64) begin
        chk({tag, "/strobe"}, {30'd0, rds[w], wrs[w]}, {30'd0, !st, st});
        chk({tag, "/address"}, adr[w], {a[31:2], 2'b00});
        chk({tag, "/byteenable"}, 32'(beo[w]), 32'(be));
        if (st) chk({tag, "/writedata"}, wdo[w], wdx);
        waitrequest = (cyc < waits);
        @(posedge clk); #1;
        cyc++;
      end
      waitrequest = 1'b0;
      chk({tag, "/strobe_cycles"}, 32'(cyc), 32'(exp_cycles));
      chk({tag, "/resp_valid"}, 32'(rv[w]), 32'd1);
      chk({tag, "/resp_err"}, 32'(rerr[w]), 32'(abort));
      chk({tag, "/resp_data"}, rdat[w], abort ? 32'd0 : res);
      chk({tag, "/strobe_off"}, {30'd0, rds[w], wrs[w]}, 32'd0);
    end
    @(posedge clk); #1;
    chk({tag, "/pulse_end"}, 32'(rv[w]), 32'd0);
    chk({tag, "/ready_again"}, 32'(rdy[w]), 32'd1);
  endtask

  initial begin
    reset = 1'b0; req_valid = 2'b00; req_op = '0; req_addr = '0; req_wdata = '0;
    req_rt_old = '0; readdata = '0; waitrequest = 1'b0;
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("reset/ready", 32'(rdy[i]), 32'd1);
      chk("reset/strobes", {28'd0, rds[i], wrs[i], rv[i], rerr[i]}, 32'd0);
      chk("reset/address", adr[i], 32'd0);
      chk("reset/writedata", wdo[i], 32'd0);
      chk("reset/resp_data", rdat[i], 32'd0);
      chk("reset/byteenable", 32'(beo[i]), 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;

    access(0, 4'd0, 32'h1000, 32'h0, 32'h0, 32'h8899_AABB, 2, "lw_wait2");
    access(0, 4'd3, 32'h1003, 32'h0, 32'h0, 32'h8011_2233, 0, "lb_le");
    access(0, 4'd4, 32'h1003, 32'h0, 32'h0, 32'h8011_2233, 1, "lbu_le");
    access(1, 4'd3, 32'h1003, 32'h0, 32'h0, 32'h8011_2233, 0, "lb_be");
    access(0, 4'd8, 32'h2002, 32'h0000_BEEF, 32'h0, 32'h0, 0, "sh_le");
    access(0, 4'd5, 32'h3001, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 0, "lwl_le");
    access(0, 4'd6, 32'h3001, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 0, "lwr_le");
    access(0, 4'd5, 32'h3003, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 0, "lwl_l3");
    access(0, 4'd6, 32'h3000, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 0, "lwr_l0");
    access(0, 4'd0, 32'h4002, 32'h0, 32'h0, 32'h1234_5678, 0, "lw_misaligned");
    access(0, 4'd12, 32'h4000, 32'h0, 32'h0, 32'h1234_5678, 0, "illegal_op");
    access(1, 4'd1, 32'h4001, 32'h0, 32'h0, 32'h1234_5678, 0, "lh_odd");
    access(0, 4'd9, 32'h5001, 32'h0000_00A5, 32'h0, 32'h0, 3, "sb_le");
    access(0, 4'd0, 32'h6000, 32'h0, 32'h0, 32'hDEAD_BEEF, 10, "timeout");
    access(0, 4'd7, 32'h6004, 32'hCAFE_F00D, 32'h0, 32'h0, 0, "sw_after_timeout");
    access(1, 4'd0, 32'h6000, 32'h0, 32'h0, 32'hDEAD_BEEF, 9, "long_wait_no_timeout");

    for (int i = 0; i < 60; i++) begin
      access(i % 2, 4'($urandom_range(0, 12)), $urandom, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 5)), "random");
    end

    // Reset in the middle of a stalled read drops the strobe at once.
    req_op = 4'd0; req_addr = 32'h7000; waitrequest = 1'b1; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("midreset/read_before", 32'(rds[0]), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midreset/read_async", 32'(rds[0]), 32'd0);
    chk("midreset/ready_async", 32'(rdy[0]), 32'd1);
    reset = 1'b1; waitrequest = 1'b0;
    @(posedge clk); #1;
    chk("midreset/ready_after", 32'(rdy[0]), 32'd1);
    chk("midreset/no_resp", 32'(rv[0]), 32'd0);
    access(0, 4'd2, 32'h7002, 32'h0, 32'h0, 32'hF00D_1234, 0, "lhu_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_bus_lsu.md
# mips_bus_lsu

Parametrised load/store unit for the MIPS I CPU. It sits between the CPU execute stage and the Avalon memory-mapped master port. It takes one memory request at a time and drives a single Avalon read or write, holding it through `waitrequest`. It then returns a lane-selected, sign/zero-extended or LWL/LWR-merged result. Endianness and a bus timeout are configurable; misaligned and illegal requests are rejected without a bus cycle.

## Interface
- `BIG_ENDIAN`, default 0: byte lane mapping. 0 means address offset k uses lane k; 1 means offset k uses lane 3-k.
- `TIMEOUT`, default 0: maximum cycles `waitrequest` may stay high before the access is aborted. 0 disables the timeout.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and accepting requests.
- `req_op` in 4: operation code. 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 LWL, 6 LWR, 7 SW, 8 SH, 9 SB. Codes 10–15 are illegal.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, taken from the low bits for SB/SH.
- `req_rt_old` in 32: current rt value, used for the LWL/LWR merge.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out 32: load result. 0 for stores and errors.
- `resp_err` out 1: qualifies `resp_valid`. Set for misaligned, illegal or timed-out accesses.
- `address` out 32: Avalon word address, always `{addr[31:2],2'b00}`.
- `read`, `write` out 1 each: Avalon strobes.
- `waitrequest` in 1: Avalon stall.
- `writedata` out 32: Avalon write data.
- `byteenable` out 4: Avalon byte enables.
- `readdata` in 32: Avalon read data.

## Operation
- **States:**
  - IDLE: `req_ready`=1.
  - BUS: strobe asserted.
  - RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- **Accept (IDLE, `req_valid`=1):**
  - All request fields are latched.
  - An illegal op, LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0 goes directly to RESP with `resp_err`=1. No strobe is issued.
  - Any other request goes to BUS.
- **Lane selection:**
  - Byte lane: `l = addr[1:0] XOR {2{BIG_ENDIAN}}`.
  - Halfword pair: `h = addr[1] XOR BIG_ENDIAN`. h=1 selects lanes 3:2; h=0 selects lanes 1:0.
- **Byte enables:**
  - LW/SW: 1111.
  - LB/LBU/SB: one-hot at lane l.
  - LH/LHU/SH: 1100 when h=1, else 0011.
  - LWL: lanes 0..l.
  - LWR: lanes l..3.
- **Write data:**
  - SB: byte replicated into all 4 lanes.
  - SH: halfword replicated into both halves.
  - SW: unchanged.
- **Load results:**
  - LB/LH: sign-extended from the selected lane(s).
  - LBU/LHU: zero-extended from the selected lane(s).
  - LW: `readdata` unchanged.
  - LWL: `(readdata << 8*(3-l)) | (rt_old & (32'hFFFFFFFF >> 8*(l+1)))`. At l=3 the result is `readdata`.
  - LWR: `(readdata >> 8*l) | (rt_old & ~(32'hFFFFFFFF >> 8*l))`. At l=0 the result is `readdata`.
- **BUS state:**
  - `address`, `byteenable`, `writedata` and the active strobe stay stable while `waitrequest`=1.
  - The transfer completes in the first BUS cycle with `waitrequest`=0. `readdata` is sampled in that same cycle and the unit moves to RESP.
- **Timeout:**
  - A counter increments each BUS cycle with `waitrequest`=1.
  - With `TIMEOUT`>0, when the counter reaches `TIMEOUT` the strobe drops and the unit goes to RESP with `resp_err`=1.
  - A later `waitrequest` fall is ignored.
- `read` and `write` are never high together.
- `req_valid` outside IDLE is ignored.

## Timing
- All outputs are registered.
- **Reset values:**
  - `req_ready`=1.
  - `read`, `write`, `resp_valid`, `resp_err` = 0.
  - `address`, `writedata`, `resp_data` = 0.
  - `byteenable` = 0000.
  - State IDLE.
- **Request-to-response timing:**
  - A request accepted at edge N has its strobe high from N+1.
  - If `waitrequest` is low in that cycle, `resp_valid` is high in cycle N+2.
  - Each `waitrequest` cycle adds one cycle of latency.
  - A rejected request gives `resp_valid` in cycle N+1.
- Back-to-back: the next request can be accepted in the cycle after RESP, so throughput is at most one access per 3 cycles.
- Reset asserted mid-BUS immediately deasserts the strobes. No response is produced for the aborted access.

## Test plan
- LW at 0x1000, `readdata`=0x8899AABB, `waitrequest` high for 2 cycles → strobe held 3 cycles, `byteenable`=1111, `resp_data`=0x8899AABB, `resp_err`=0.
- LB at 0x1003 (BIG_ENDIAN=0), `readdata`=0x80112233 → `byteenable`=1000, `resp_data`=0xFFFFFF80. Same access as LBU → 0x00000080. With BIG_ENDIAN=1, LB at 0x1003 → lane 0, `resp_data`=0x00000033.
- SH at 0x2002, `req_wdata`=0x0000BEEF (LE) → `write`=1, `byteenable`=1100, `writedata`=0xBEEFBEEF, response with `resp_data`=0.
- LWL at 0x3001 (LE) with `readdata`=0x11223344 and `rt_old`=0xAABBCCDD → `byteenable`=0011, `resp_data`=0x3344CCDD. LWR at the same address → `byteenable`=1110, `resp_data`=0xAA112233.
- LW at 0x4002 → no strobe, `resp_valid`+`resp_err` in cycle N+1. `req_op`=12 → same response.
- TIMEOUT=4 with `waitrequest` stuck high → strobe drops after 4 cycles, `resp_err`=1, next request accepted. Reset pulled mid-BUS → `read`=0 asynchronously, `req_ready`=1 after release.
